// File: rtl/l2_mem_arbiter.sv
// Arbiter sharing one 128-bit line memory port between the I-side and D-side L2 caches.
// It serialises line transfers, keeps a writeback/refill pair atomic and counts grants per port.
module l2_mem_arbiter #(
  parameter bit FIXED_PRI = 1'b0,
  parameter int CNTW      = 16
) (
  input  logic            clk,
  input  logic            proc_reset,
  input  logic            i_read,
  input  logic            i_write,
  input  logic [27:0]     i_addr,
  input  logic [127:0]    i_wdata,
  output logic [127:0]    i_rdata,
  output logic            i_ready,
  input  logic            d_read,
  input  logic            d_write,
  input  logic [27:0]     d_addr,
  input  logic [127:0]    d_wdata,
  output logic [127:0]    d_rdata,
  output logic            d_ready,
  output logic            mem_read,
  output logic            mem_write,
  output logic [27:0]     mem_addr,
  output logic [127:0]    mem_wdata,
  input  logic [127:0]    mem_rdata,
  input  logic            mem_ready,
  output logic [CNTW-1:0] i_grant_cnt,
  output logic [CNTW-1:0] d_grant_cnt
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t state;
  logic   rr_d;      // round-robin pointer: 0 = I next, 1 = D next
  logic   lock_vld;
  logic   lock_d;    // locked port: 0 = I, 1 = D

  logic req_i, req_d, lock_hit;

  assign req_i = i_read ^ i_write;
  assign req_d = d_read ^ d_write;

  // The locked port keeps the memory only for the refill read that follows its writeback.
  assign lock_hit = lock_vld && (lock_d ? (d_read && !d_write) : (i_read && !i_write));

  // NOTE: all state lives in one clocked block with non-blocking assignments, so every
  // register samples the pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state       <= IDLE;
      rr_d        <= 1'b0;
      lock_vld    <= 1'b0;
      lock_d      <= 1'b0;
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          lock_vld <= 1'b0;
          if (lock_hit) begin
            state <= lock_d ? GNT_D : GNT_I;
          end else if (req_i && req_d) begin
            state <= (FIXED_PRI || rr_d) ? GNT_D : GNT_I;
          end else if (req_i) begin
            state <= GNT_I;
          end else if (req_d) begin
            state <= GNT_D;
          end
        end
        GNT_I: begin
          if (mem_ready) begin
            state       <= IDLE;
            i_grant_cnt <= i_grant_cnt + CNTW'(1);
            rr_d        <= 1'b1;
            if (i_write) begin
              lock_vld <= 1'b1;
              lock_d   <= 1'b0;
            end
          end else if (!req_i) begin
            state <= IDLE;
          end
        end
        GNT_D: begin
          if (mem_ready) begin
            state       <= IDLE;
            d_grant_cnt <= d_grant_cnt + CNTW'(1);
            rr_d        <= 1'b0;
            if (d_write) begin
              lock_vld <= 1'b1;
              lock_d   <= 1'b1;
            end
          end else if (!req_d) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_rdata   = '0;
    i_ready   = 1'b0;
    d_rdata   = '0;
    d_ready   = 1'b0;
    case (state)
      GNT_I: begin
        mem_read  = i_read;
        mem_write = i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_rdata   = mem_rdata;
        i_ready   = mem_ready;
      end
      GNT_D: begin
        mem_read  = d_read;
        mem_write = d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_rdata   = mem_rdata;
        d_ready   = mem_ready;
      end
      default: ;
    endcase
  end

endmodule
